// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN feature-map buffer.
// Holds the pool FSM states, default pooled-map geometry and the saturator.
package cnn_pkg;

  localparam int MAP_W_DEF = 28;
  localparam int MAP_H_DEF = 28;
  localparam int POOL_W    = MAP_W_DEF / 2;
  localparam int POOL_H    = MAP_H_DEF / 2;
  localparam int WINDOWS   = POOL_W * POOL_H;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_FIN
  } pool_state_e;

  // Clamp a signed sum into the signed range of a data_w-bit element.
  function automatic int sat_to_data(input int sum, input int data_w);
    int hi;
    int lo;
    hi = (1 <<< (data_w - 1)) - 1;
    lo = -hi - 1;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/fmap_bank.sv
// One channel bank: simple-dual-port RAM, 1-cycle registered read.
// Ports: we_i/waddr_i/wdata_i write, re_i/raddr_i read, rdata_o data.
module fmap_bank #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 784,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Same-address read and write return the old word.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fmap_pool_buffer.sv
// Per-channel feature-map buffer: bias+saturate store, in-place 2x2 max-pool
// with optional ReLU, parallel read-out. Ports: store_*, pool_*, rd_*.
module fmap_pool_buffer
  import cnn_pkg::*;
#(
  parameter int CHANNELS = 16,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 16,
  parameter int MAP_W    = MAP_W_DEF,
  parameter int MAP_H    = MAP_H_DEF,
  parameter int ADDR_W   = $clog2(MAP_W * MAP_H),
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       store_valid,
  input  logic [CH_W-1:0]            store_ch,
  input  logic [ADDR_W-1:0]          store_addr,
  input  logic [ACC_W-1:0]           store_acc,
  input  logic [DATA_W-1:0]          store_bias,
  output logic                       store_err,
  input  logic                       pool_start,
  input  logic                       relu_en,
  output logic                       pool_busy,
  output logic                       pool_done,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic                       rd_valid,
  output logic [CHANNELS*DATA_W-1:0] rd_data
);

  localparam int PW    = MAP_W / 2;
  localparam int PH    = MAP_H / 2;
  localparam int NWIN  = PW * PH;
  localparam int DEPTH = MAP_W * MAP_H;

  pool_state_e       state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [ADDR_W-1:0] w_q, w_d;
  logic [ADDR_W-1:0] wc_q, wc_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              relu_q, relu_d;
  logic              err_q, rdv_q;

  logic              busy, st_ok, pool_we, bank_re;
  logic [ADDR_W-1:0] off, pool_ra, bank_ra, bank_wa;
  logic [CH_W:0]     ch_ext;
  logic signed [ACC_W:0] sum;
  logic [DATA_W-1:0] st_data;

  assign busy    = (state_q != S_IDLE);
  assign pool_we = (state_q == S_WR);

  assign sum = {store_acc[ACC_W-1], store_acc}
             + {{(ACC_W + 1 - DATA_W){store_bias[DATA_W-1]}}, store_bias};
  assign st_data = DATA_W'(sat_to_data(int'(sum), DATA_W));

  assign ch_ext = {1'b0, store_ch};
  assign st_ok  = store_valid && !busy
               && (ch_ext < (CH_W + 1)'(CHANNELS));

  always_comb begin
    off = '0;
    unique case (k_q)
      2'd0: off = '0;
      2'd1: off = ADDR_W'(1);
      2'd2: off = ADDR_W'(MAP_W);
      2'd3: off = ADDR_W'(MAP_W + 1);
      default: off = '0;
    endcase
  end

  assign pool_ra = base_q + off;
  assign bank_ra = busy ? pool_ra : rd_addr;
  assign bank_re = busy ? (state_q == S_RD) : rd_en;
  assign bank_wa = busy ? w_q : store_addr;

  // base tracks 2*row*MAP_W + 2*col incrementally; a row wrap
  // jumps from the last window's column to the next pair of rows.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    w_d     = w_q;
    wc_d    = wc_q;
    base_d  = base_q;
    relu_d  = relu_q;
    unique case (state_q)
      S_IDLE: begin
        if (pool_start) begin
          relu_d  = relu_en;
          w_d     = '0;
          wc_d    = '0;
          base_d  = '0;
          k_d     = '0;
          state_d = S_RD;
        end
      end
      S_RD: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = S_WR;
      end
      S_WR: begin
        if (w_q == ADDR_W'(NWIN - 1)) begin
          state_d = S_FIN;
        end else begin
          w_d     = w_q + ADDR_W'(1);
          k_d     = '0;
          state_d = S_RD;
          if (wc_q == ADDR_W'(PW - 1)) begin
            wc_d   = '0;
            base_d = base_q + ADDR_W'(MAP_W + 2);
          end else begin
            wc_d   = wc_q + ADDR_W'(1);
            base_d = base_q + ADDR_W'(2);
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      w_q     <= '0;
      wc_q    <= '0;
      base_q  <= '0;
      relu_q  <= 1'b0;
      err_q   <= 1'b0;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      w_q     <= w_d;
      wc_q    <= wc_d;
      base_q  <= base_d;
      relu_q  <= relu_d;
      err_q   <= err_q | (store_valid & busy);
      rdv_q   <= rd_en & ~busy;
    end
  end

  assign store_err = err_q;
  assign pool_busy = busy;
  assign pool_done = (state_q == S_FIN);
  assign rd_valid  = rdv_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic signed [DATA_W-1:0] rdata, m_q, mx, pooled, hold_q;
    logic [DATA_W-1:0]        wdata;
    logic                     we;

    assign we = busy ? pool_we
                     : (st_ok && (store_ch == CH_W'(g)));

    // Running max: element 0 lands in RD1, element 3 in WR.
    assign mx     = (rdata > m_q) ? rdata : m_q;
    assign pooled = (relu_q && mx[DATA_W-1]) ? '0 : mx;
    assign wdata  = busy ? pooled : st_data;

    fmap_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (bank_wa),
      .wdata_i (wdata),
      .re_i    (bank_re),
      .raddr_i (bank_ra),
      .rdata_o (rdata)
    );

    always_ff @(posedge clk) begin
      if (state_q == S_RD && k_q == 2'd1) m_q <= rdata;
      else if (state_q == S_RD && k_q != 2'd0) m_q <= mx;
    end

    // Pool traffic also moves the bank output, so the last
    // host read is kept separately for rd_data to hold.
    always_ff @(posedge clk) begin
      if (rst) hold_q <= '0;
      else if (rdv_q) hold_q <= rdata;
    end

    assign rd_data[g*DATA_W +: DATA_W] = rdv_q ? rdata : hold_q;
  end

endmodule

// File: tb/tb_fmap_pool_buffer.sv
// Scoreboard bench for fmap_pool_buffer against an array model.
// Stores, pools and read-outs are randomized and checked per read.
module tb_fmap_pool_buffer;

  localparam int CH    = 16;
  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int MW    = 28;
  localparam int MH    = 28;
  localparam int DEPTH = MW * MH;
  localparam int ADW   = 10;
  localparam int PW    = MW / 2;
  localparam int PH    = MH / 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           store_valid = 1'b0;
  logic [3:0]     store_ch = '0;
  logic [ADW-1:0] store_addr = '0;
  logic [AW-1:0]  store_acc = '0;
  logic [DW-1:0]  store_bias = '0;
  logic           store_err;
  logic           pool_start = 1'b0;
  logic           relu_en = 1'b0;
  logic           pool_busy;
  logic           pool_done;
  logic           rd_en = 1'b0;
  logic [ADW-1:0] rd_addr = '0;
  logic           rd_valid;
  logic [CH*DW-1:0] rd_data;

  always #5 clk = ~clk;

  fmap_pool_buffer #(
    .CHANNELS (CH),
    .DATA_W   (DW),
    .ACC_W    (AW),
    .MAP_W    (MW),
    .MAP_H    (MH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .store_valid (store_valid),
    .store_ch    (store_ch),
    .store_addr  (store_addr),
    .store_acc   (store_acc),
    .store_bias  (store_bias),
    .store_err   (store_err),
    .pool_start  (pool_start),
    .relu_en     (relu_en),
    .pool_busy   (pool_busy),
    .pool_done   (pool_done),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data)
  );

  int errors = 0;
  int checks = 0;
  int mem [CH][DEPTH];
  logic [CH*DW-1:0] q_exp [$];
  logic [CH*DW-1:0] mon_exp;

  function automatic int sat_ref(input int s);
    if (s > 127) return 127;
    if (s < -128) return -128;
    return s;
  endfunction

  function automatic logic [CH*DW-1:0] expv(input int a);
    logic [CH*DW-1:0] v;
    for (int k = 0; k < CH; k++) v[k*DW +: DW] = DW'(mem[k][a]);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input integer act,
                     input integer exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      checks++;
      if (q_exp.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: data %h with no read pending",
                 rd_data);
      end else begin
        mon_exp = q_exp.pop_front();
        if (rd_data !== mon_exp) begin
          errors++;
          $display("FAIL rd_data: got %h expected %h",
                   rd_data, mon_exp);
        end
      end
    end
  end

  task automatic put(input int ch, input int a,
                     input int acc, input int b);
    store_valid = 1'b1;
    store_ch    = 4'(ch);
    store_addr  = ADW'(a);
    store_acc   = AW'(acc);
    store_bias  = DW'(b);
    tick();
    store_valid = 1'b0;
  endtask

  // Channel 0 gets the ramp (a mod 100) - 50, others random sums.
  task automatic fill(input int c0, input int c1,
                      input int a0, input int a1);
    int v, b, acc;
    for (int ch = c0; ch <= c1; ch++) begin
      for (int a = a0; a <= a1; a++) begin
        if (ch == 0) begin
          v   = (a % 100) - 50;
          b   = int'($urandom_range(0, 40)) - 20;
          acc = v - b;
        end else begin
          acc = int'($urandom_range(0, 800)) - 400;
          b   = int'($urandom_range(0, 255)) - 128;
          v   = sat_ref(acc + b);
        end
        put(ch, a, acc, b);
        mem[ch][a] = v;
      end
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      rd_en   = 1'b1;
      rd_addr = ADW'(a);
      q_exp.push_back(expv(a));
      tick();
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic rd_direct(input int a, input int ch,
                           input int exp, input string nm);
    logic signed [DW-1:0] b;
    rd_en   = 1'b1;
    rd_addr = ADW'(a);
    q_exp.push_back(expv(a));
    tick();
    rd_en = 1'b0;
    chk({nm, "_valid"}, rd_valid, 1);
    b = rd_data[ch*DW +: DW];
    chk(nm, b, exp);
    tick();
    chk({nm, "_hold"}, rd_data === expv(a), 1);
  endtask

  task automatic model_pool(input bit relu);
    int tmp [CH][PW*PH];
    int m, base;
    for (int ch = 0; ch < CH; ch++)
      for (int r = 0; r < PH; r++)
        for (int c = 0; c < PW; c++) begin
          base = 2 * r * MW + 2 * c;
          m = mem[ch][base];
          if (mem[ch][base + 1] > m) m = mem[ch][base + 1];
          if (mem[ch][base + MW] > m) m = mem[ch][base + MW];
          if (mem[ch][base + MW + 1] > m) m = mem[ch][base + MW + 1];
          if (relu && m < 0) m = 0;
          tmp[ch][r * PW + c] = m;
        end
    for (int ch = 0; ch < CH; ch++)
      for (int i = 0; i < PW * PH; i++) mem[ch][i] = tmp[ch][i];
  endtask

  // Also injects a colliding store, a read and a second start.
  task automatic run_pool(input bit relu);
    int n;
    bit seen;
    pool_start = 1'b1;
    relu_en    = relu;
    tick();
    pool_start = 1'b0;
    relu_en    = ~relu;
    n = 1;
    seen = 1'b0;
    chk("busy_rise", pool_busy, 1);
    while (n < 2000) begin
      if (pool_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      store_valid = (n == 10);
      store_ch    = 4'd0;
      store_addr  = ADW'(300);
      store_acc   = AW'(77);
      store_bias  = '0;
      rd_en       = (n == 15);
      rd_addr     = ADW'(5);
      pool_start  = (n == 20);
      tick();
      n++;
    end
    store_valid = 1'b0;
    rd_en       = 1'b0;
    pool_start  = 1'b0;
    relu_en     = 1'b0;
    chk("pool_done_seen", seen, 1);
    chk("pool_done_cycle", n, 981);
    tick();
    chk("done_one_cycle", pool_done, 0);
    chk("busy_fall", pool_busy, 0);
    model_pool(relu);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_busy", pool_busy, 0);
    chk("rst_done", pool_done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data === '0, 1);
    chk("rst_store_err", store_err, 0);
    rst = 1'b0;
    tick();

    fill(0, CH - 1, 0, DEPTH - 1);

    put(1, 700, 300, 5);
    mem[1][700] = 127;
    put(1, 701, -200, -3);
    mem[1][701] = -128;
    put(1, 702, 10, -4);
    mem[1][702] = 6;
    rd_direct(700, 1, 127, "sat_pos");
    rd_direct(701, 1, -128, "sat_neg");
    rd_direct(702, 1, 6, "sat_mid");
    rd_direct(195, 7, mem[7][195], "rd_195");

    put(3, 50, -7, 0);
    mem[3][50] = -7;
    rd_en       = 1'b1;
    rd_addr     = ADW'(50);
    store_valid = 1'b1;
    store_ch    = 4'd3;
    store_addr  = ADW'(50);
    store_acc   = AW'(100);
    store_bias  = '0;
    q_exp.push_back(expv(50));
    tick();
    mem[3][50]  = 100;
    store_valid = 1'b0;
    q_exp.push_back(expv(50));
    tick();
    rd_en = 1'b0;
    tick();

    for (int i = 0; i < 20; i++) begin
      rd_en   = 1'b1;
      rd_addr = ADW'($urandom_range(0, DEPTH - 1));
      q_exp.push_back(expv(int'(rd_addr)));
      tick();
    end
    rd_en = 1'b0;
    tick();

    run_pool(1'b0);
    read_all();
    rd_direct(0, 0, -21, "pool_addr0");
    rd_direct(300, 0, mem[0][300], "collision_addr");
    chk("store_err_set", store_err, 1);

    fill(0, 0, 0, DEPTH - 1);
    run_pool(1'b1);
    read_all();
    rd_direct(0, 0, 0, "relu_addr0");
    chk("store_err_sticky", store_err, 1);

    pool_start = 1'b1;
    tick();
    pool_start = 1'b0;
    for (int n = 1; n < 100; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", pool_busy, 0);
    chk("abort_done", pool_done, 0);
    chk("abort_err_clear", store_err, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_quiet", pool_done | pool_busy, 0);
    end

    fill(0, CH - 1, 0, 19);
    run_pool(1'b0);
    read_all();

    tick();
    tick();
    chk("scoreboard_drained", q_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fmap_pool_buffer.md
# fmap_pool_buffer

Parametrised per-channel feature-map buffer for the CNN datapath. It sits between a convolution engine and the next layer. Conv results arrive with a bias; the block adds the bias, saturates the sum and stores it. It then runs an in-place 2×2 stride-2 max-pool with optional ReLU, compacting each pooled map to the low addresses. Finally it serves read-out of all channels in parallel to the next layer. It generalises the single-size, fixed-channel layer memory: channel count, widths and map size are parameters, and it adds a pool-mode input, a busy/done handshake, a store-collision flag and registered read data.

## Interface
- CHANNELS, 16, number of independent channel banks
- DATA_W, 8, stored element width (signed)
- ACC_W, 16, incoming accumulator width (signed)
- MAP_W, 28, map width in elements (even)
- MAP_H, 28, map height in elements (even)
- ADDR_W, $clog2(MAP_W*MAP_H), derived address width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- store_valid  in  1  write one conv result this cycle
- store_ch  in  $clog2(CHANNELS)  target bank
- store_addr  in  ADDR_W  row-major address r*MAP_W+c
- store_acc  in  ACC_W  signed accumulator value
- store_bias  in  DATA_W  signed bias
- store_err  out  1  sticky: a store arrived while pool_busy
- pool_start  in  1  start pooling all channels
- relu_en  in  1  ReLU on pooled output, sampled at pool_start
- pool_busy  out  1  pooling in progress
- pool_done  out  1  one-cycle pulse at pool completion
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address, same in all banks
- rd_valid  out  1  rd_data valid
- rd_data  out  CHANNELS*DATA_W  channel k at bits [k*DATA_W +: DATA_W]

## Operation
- Store arithmetic:
  - sum = store_acc + sign-extended store_bias, computed in ACC_W+1 bits.
  - Saturate sum to [-2^(DATA_W-1), 2^(DATA_W-1)-1], then write to bank store_ch at store_addr.
  - Example at DATA_W=8: 300 → 127; -200 → -128.
- Store collisions:
  - If store_valid is high while pool_busy is high, the store is dropped and store_err is set.
  - store_err is cleared only by rst.
- Out-of-range store_ch: if store_ch ≥ CHANNELS, the store is ignored.
- Pool FSM states: IDLE → RD (sub-step k=0..3) → WR → RD … → FIN → IDLE.
  - IDLE: pool_start=1 latches relu_en, clears the window index w, and enters RD k=0.
  - RD k: issues reads to every bank at base+{0, 1, MAP_W, MAP_W+1}[k].
    - base = 2*(w / (MAP_W/2))*MAP_W + 2*(w mod (MAP_W/2)).
  - WR: receives the fourth element and forms the signed max of the four.
    - If relu_en was latched, applies max(m, 0).
    - Writes the result to address w in every bank.
  - After WR: if w = (MAP_W/2)*(MAP_H/2) − 1, go to FIN; otherwise increment w and go to RD k=0.
  - FIN: pulses pool_done and returns to IDLE.
- Compaction is hazard-free: for every window, w < base of every later window, so a write never clobbers an unread element.
- Pooled map layout: row-major (MAP_W/2)×(MAP_H/2) at addresses 0..(MAP_W*MAP_H/4 − 1). Higher addresses keep stale data.
- Requests ignored while busy:
  - pool_start while pool_busy is ignored.
  - rd_en while pool_busy is ignored; rd_valid stays 0.
- Simultaneous store_valid and rd_en in IDLE at the same bank and address: the read returns the old data (read-before-write).

## Timing
- Reset values:
  - pool_busy=0, pool_done=0, rd_valid=0, rd_data=0, store_err=0; FSM in IDLE.
  - Memory contents are not reset.
- Reset mid-pool aborts immediately: the next cycle is IDLE with no pool_done pulse. Partially pooled data is left as-is.
- Store: written on the edge where store_valid=1; readable starting with a read issued the next cycle.
- Read: rd_data and rd_valid are registered and appear one cycle after rd_en. rd_data holds its value when rd_en=0.
- Bank read latency is 1 cycle. Each window takes 5 cycles (RD×4 + WR).
- Pool sequence:
  - pool_busy rises the cycle after pool_start.
  - Total busy cycles = 5*(MAP_W/2)*(MAP_H/2) + 1, counting FIN. This is 981 for 28×28.
  - pool_done is high in the FIN cycle. pool_busy drops the cycle after FIN.
- A new pool_start is accepted in the first IDLE cycle after FIN.

## Structure
- Package cnn_pkg holds:
  - the sat_to_data(ACC_W+1 → DATA_W) function
  - the pool FSM state enum
  - the localparams POOL_W=MAP_W/2, POOL_H=MAP_H/2, WINDOWS=POOL_W*POOL_H
- Sub-module fmap_bank:
  - one simple-dual-port RAM with DATA_W × MAP_W*MAP_H entries, block-RAM style
  - 1-cycle registered read, read-before-write
  - instantiated CHANNELS times via generate
- Top level holds: the write-port mux (store vs pool WR), the read-address mux (rd_addr vs pool address), the max/ReLU datapath, and the FSM.

## Test plan
- Saturation: store_acc=300, bias=5 → read 127; store_acc=-200, bias=-3 → -128; store_acc=10, bias=-4 → 6.
- Pool ramp: channel 0 filled with value = (addr mod 100) − 50, relu_en=0, then pool → addr 0 holds max(−50, −49, −22, −21) = −21; pool_done exactly 981 cycles after pool_start.
- ReLU: same fill as above, relu_en=1 → addr 0 reads 0, and every pooled value is ≥ 0; the other 15 channels pool in parallel correctly.
- Collision: store_valid during pool_busy → target address unchanged and store_err=1 until rst; a repeated pool_start during busy has no effect.
- Reset mid-pool: rst asserted at busy cycle 100 → next cycle pool_busy=0 with no pool_done; a fresh pool_start then completes normally.
- Read path: rd_en at addr 195 → rd_valid one cycle later with all 16 channel bytes placed correctly in rd_data.
